// File: rtl/fc_feature_server.sv
// Feature buffer between the pooling/flatten stage and the FC engine.
// Collects one frame of bytes, starts the FC engine, then serves its reads.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for the first write of a frame
// FILL   | accepting writes until the frame byte count is reached
// READY  | single-cycle valid pulse to the FC engine
// SERVE  | FC engine reading features; ends on fc_done
module fc_feature_server #(
   parameter int NUM_BANKS  = 64,
   parameter int DEPTH      = 2048,
   parameter int FRAME_LEN1 = 16384,
   parameter int FRAME_LEN0 = 8192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode,
   input  logic        wr_en,
   input  logic [5:0]  wr_bank,
   input  logic [10:0] wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        rd_en,
   input  logic [5:0]  rd_bank,
   input  logic [10:0] rd_addr,
   input  logic        fc_done,
   output logic        valid,
   output logic [7:0]  fc1_data,
   output logic        mode_q,
   output logic        busy,
   output logic        err_wr
);

   localparam int MEM_WORDS = NUM_BANKS * DEPTH;
   localparam int AW        = $clog2(MEM_WORDS);

   localparam logic [16:0] FL1 = 17'(FRAME_LEN1);
   localparam logic [16:0] FL0 = 17'(FRAME_LEN0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_SERVE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [16:0]   wr_cnt_q, wr_cnt_d;
   logic          mode_d;
   logic          err_wr_q, err_wr_d;

   logic [7:0]    mem [MEM_WORDS];
   logic          mem_we;
   logic          wr_in_range;
   logic [AW-1:0] wr_idx;
   logic [16:0]   cnt_inc;
   logic [16:0]   len_first;
   logic [16:0]   len_cur;

   logic          rd_v1_q, rd_v1_d;
   logic          rd_serve1_q, rd_serve1_d;
   logic [5:0]    rd_bank1_q, rd_bank1_d;
   logic [10:0]   rd_addr1_q, rd_addr1_d;
   logic          rd_in_range;
   logic [AW-1:0] rd_idx;
   logic [7:0]    fc1_data_q, fc1_data_d;

   always_comb begin
      wr_in_range = (32'(wr_bank) < 32'(NUM_BANKS)) && (32'(wr_addr) < 32'(DEPTH));
      wr_idx      = '0;
      if (wr_in_range) begin
         wr_idx = AW'(wr_bank) * AW'(DEPTH) + AW'(wr_addr);
      end
   end

   always_comb begin
      len_first = mode   ? FL1 : FL0;
      len_cur   = mode_q ? FL1 : FL0;
      cnt_inc   = wr_cnt_q + 17'd1;
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      mode_d   = mode_q;
      err_wr_d = err_wr_q;
      mem_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_en) begin
               mode_d   = mode;
               wr_cnt_d = 17'd1;
               mem_we   = wr_in_range;
               if (!wr_in_range) err_wr_d = 1'b1;
               state_d  = (len_first == 17'd1) ? ST_READY : ST_FILL;
            end
         end
         ST_FILL: begin
            if (wr_en) begin
               // out-of-range bytes still count toward the frame length
               mem_we   = wr_in_range;
               if (!wr_in_range) err_wr_d = 1'b1;
               wr_cnt_d = cnt_inc;
               if (cnt_inc == len_cur) state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (wr_en) err_wr_d = 1'b1;
            state_d = ST_SERVE;
         end
         ST_SERVE: begin
            if (wr_en) err_wr_d = 1'b1;
            if (fc_done) begin
               state_d  = ST_IDLE;
               wr_cnt_d = 17'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_idx] <= wr_data;
   end

   always_comb begin
      rd_v1_d     = rd_en;
      rd_serve1_d = rd_en && (state_q == ST_SERVE);
      rd_bank1_d  = rd_bank;
      rd_addr1_d  = rd_addr;
   end

   always_comb begin
      rd_in_range = (32'(rd_bank1_q) < 32'(NUM_BANKS)) && (32'(rd_addr1_q) < 32'(DEPTH));
      rd_idx      = '0;
      if (rd_in_range) begin
         rd_idx = AW'(rd_bank1_q) * AW'(DEPTH) + AW'(rd_addr1_q);
      end
      fc1_data_d = fc1_data_q;
      if (rd_v1_q) begin
         fc1_data_d = (rd_serve1_q && rd_in_range) ? mem[rd_idx] : 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_cnt_q    <= 17'd0;
         mode_q      <= 1'b0;
         err_wr_q    <= 1'b0;
         rd_v1_q     <= 1'b0;
         rd_serve1_q <= 1'b0;
         rd_bank1_q  <= 6'd0;
         rd_addr1_q  <= 11'd0;
         fc1_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         mode_q      <= mode_d;
         err_wr_q    <= err_wr_d;
         rd_v1_q     <= rd_v1_d;
         rd_serve1_q <= rd_serve1_d;
         rd_bank1_q  <= rd_bank1_d;
         rd_addr1_q  <= rd_addr1_d;
         fc1_data_q  <= fc1_data_d;
      end
   end

   assign valid    = (state_q == ST_READY);
   assign busy     = (state_q != ST_IDLE);
   assign fc1_data = fc1_data_q;
   assign err_wr   = err_wr_q;

endmodule

// File: tb/tb_fc_feature_server.sv
// Directed bench for fc_feature_server: a full-depth instance and a
// reduced-depth instance share stimulus so out-of-range reads can be exercised.
module tb_fc_feature_server;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic        wr_en;
   logic [5:0]  wr_bank;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rd_en;
   logic [5:0]  rd_bank;
   logic [10:0] rd_addr;
   logic        fc_done;

   logic        valid, mode_q, busy, err_wr;
   logic [7:0]  fc1_data;
   logic        s_valid, s_mode_q, s_busy, s_err_wr;
   logic [7:0]  s_fc1_data;

   int n_chk  = 0;
   int n_fail = 0;
   int vcnt;

   always #5 clk = ~clk;

   fc_feature_server #(.NUM_BANKS(64), .DEPTH(2048), .FRAME_LEN1(8), .FRAME_LEN0(8)) u_dut (
      .clk(clk), .rst(rst), .mode(mode), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_bank(rd_bank),
      .rd_addr(rd_addr), .fc_done(fc_done), .valid(valid), .fc1_data(fc1_data),
      .mode_q(mode_q), .busy(busy), .err_wr(err_wr)
   );

   fc_feature_server #(.NUM_BANKS(64), .DEPTH(1024), .FRAME_LEN1(8), .FRAME_LEN0(8)) u_dut_s (
      .clk(clk), .rst(rst), .mode(mode), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_bank(rd_bank),
      .rd_addr(rd_addr), .fc_done(fc_done), .valid(s_valid), .fc1_data(s_fc1_data),
      .mode_q(s_mode_q), .busy(s_busy), .err_wr(s_err_wr)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input int b, input int a, input int d);
      wr_en   = 1'b1;
      wr_bank = 6'(b);
      wr_addr = 11'(a);
      wr_data = 8'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic rd_issue(input int b, input int a);
      rd_en   = 1'b1;
      rd_bank = 6'(b);
      rd_addr = 11'(a);
      tick();
      rd_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_bank = '0; rd_addr = '0; fc_done = 1'b0;
      tick();
      tick();
      check_val("rst_valid", valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_fc1_data", fc1_data, 0);
      check_val("rst_mode_q", mode_q, 0);
      check_val("rst_err_wr", err_wr, 0);
      rst = 1'b0;
      tick();

      // frame 1: bank 3, addr 0..7, 0x10..0x17
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         wr_byte(3, i, 8'h10 + i);
         if (i == 0) check_val("f1_busy_first", busy, 1);
         if (i < 7 && valid) vcnt++;
      end
      check_val("f1_valid_early", vcnt, 0);
      check_val("f1_valid_pulse", valid, 1);
      check_val("f1_busy_ready", busy, 1);
      tick();
      check_val("f1_valid_once", valid, 0);
      check_val("f1_busy_serve", busy, 1);

      for (int i = 0; i < 9; i++) begin
         if (i < 8) rd_issue(3, i);
         else tick();
         if (i >= 1) check_val($sformatf("f1_rd%0d", i - 1), fc1_data, 8'h10 + i - 1);
      end
      tick();
      tick();
      check_val("idle_hold", fc1_data, 8'h17);
      fc_done = 1'b1;
      tick();
      fc_done = 1'b0;
      check_val("f1_done_busy", busy, 0);
      check_val("f1_err_clean", err_wr, 0);

      // frame 2: boundary banks/addresses; small instance sees addr >= 1024 as out of range
      wr_byte(63, 5, 8'hA5);
      wr_byte(0, 2047, 8'h5A);
      rd_en = 1'b1; rd_bank = 6'd3; rd_addr = 11'd0;
      wr_byte(1, 1500, 8'hC3);
      rd_en = 1'b0;
      check_val("fill_hold", fc1_data, 8'h17);
      wr_byte(2, 0, 8'h20);
      check_val("fill_rd_zero", fc1_data, 8'h00);
      for (int i = 1; i < 5; i++) wr_byte(2, i, 8'h20 + i);
      check_val("f2_valid", valid, 1);
      check_val("f2_s_valid", s_valid, 1);
      check_val("f2_err_main", err_wr, 0);
      check_val("f2_err_small", s_err_wr, 1);
      tick();
      rd_issue(63, 5);
      rd_issue(0, 2047);
      check_val("f2_rd_b63", fc1_data, 8'hA5);
      check_val("f2_s_rd_b63", s_fc1_data, 8'hA5);
      rd_issue(1, 1500);
      check_val("f2_rd_a2047", fc1_data, 8'h5A);
      check_val("f2_s_rd_oor0", s_fc1_data, 8'h00);
      rd_issue(3, 2);
      check_val("f2_rd_a1500", fc1_data, 8'hC3);
      check_val("f2_s_rd_oor1", s_fc1_data, 8'h00);
      tick();
      check_val("f2_rd_b3a2", fc1_data, 8'h12);
      check_val("f2_s_rd_b3a2", s_fc1_data, 8'h12);

      // write colliding with fc_done in SERVE is dropped, transition still taken
      fc_done = 1'b1;
      wr_byte(3, 2, 8'hEE);
      fc_done = 1'b0;
      check_val("coll_busy", busy, 0);
      check_val("coll_err", err_wr, 1);
      fc_done = 1'b1;
      tick();
      fc_done = 1'b0;
      check_val("done_idle_ignored", busy, 0);

      // frame 3 abandoned by async reset after 5 writes
      for (int i = 0; i < 5; i++) wr_byte(4, i, 8'h40 + i);
      check_val("f3_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_busy", busy, 0);
      check_val("async_rst_err", err_wr, 0);
      check_val("async_rst_data", fc1_data, 0);
      tick();
      rst = 1'b0;
      tick();

      // frame 4: mode=1 sampled only on first write
      vcnt = 0;
      mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_byte(5, i, 8'h50 + i);
         mode = 1'b0;
         if (i < 7 && valid) vcnt++;
      end
      check_val("f4_valid_early", vcnt, 0);
      check_val("f4_valid", valid, 1);
      check_val("f4_mode_q", mode_q, 1);
      check_val("f4_err", err_wr, 0);
      tick();
      rd_issue(3, 2);
      rd_issue(5, 7);
      check_val("f4_rd_b3a2_kept", fc1_data, 8'h12);
      rd_issue(4, 1);
      check_val("f4_rd_b5a7", fc1_data, 8'h57);
      tick();
      check_val("f4_rd_b4a1_survives_rst", fc1_data, 8'h41);
      fc_done = 1'b1;
      tick();
      fc_done = 1'b0;
      check_val("f4_done_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_feature_server.md
FC_FEATURE_SERVER -- requirements
Module: fc_feature_server

Interface
REQ-001 Parameter NUM_BANKS, default 64: number of feature banks, addressed by 6-bit bank index.
REQ-002 Parameter DEPTH, default 2048: bytes per bank, addressed by 11-bit address.
REQ-003 Parameter FRAME_LEN1, default 16384: bytes per frame when mode=1.
REQ-004 Parameter FRAME_LEN0, default 8192: bytes per frame when mode=0.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mode  input  1  structure select; sampled only on the first accepted write of a frame.
REQ-008 wr_en  input  1  write strobe from the pooling/flatten stage.
REQ-009 wr_bank  input  6  write bank index.
REQ-010 wr_addr  input  11  write address within bank.
REQ-011 wr_data  input  8  feature byte.
REQ-012 rd_en  input  1  read request from the FC engine (its fc1_W_en).
REQ-013 rd_bank  input  6  read bank index (its bramnum).
REQ-014 rd_addr  input  11  read address (its bramaddr).
REQ-015 fc_done  input  1  one-cycle pulse from the FC engine: frame consumed.
REQ-016 valid  output  1  one-cycle start pulse to the FC engine.
REQ-017 fc1_data  output  8  read data to the FC engine.
REQ-018 mode_q  output  1  mode latched for the current frame.
REQ-019 busy  output  1  high in FILL, READY and SERVE states.
REQ-020 err_wr  output  1  sticky error: a write was rejected.

Function
REQ-021 State machine has four states: IDLE, FILL, READY and SERVE.
REQ-022 IDLE: wr_en=1 latches mode into mode_q, performs the write, sets wr_cnt=1, and goes to FILL, or to READY if the frame length is 1.
REQ-023 FILL: each wr_en=1 writes mem[wr_bank][wr_addr] and increments wr_cnt (17-bit).
REQ-024 FILL: the write making wr_cnt equal FRAME_LEN(mode_q) moves the state to READY on the next edge.
REQ-025 READY: lasts exactly one cycle; valid=1 only in this cycle; state then goes to SERVE.
REQ-026 SERVE: holds until fc_done=1, then goes to IDLE on the next edge and clears wr_cnt to 0.
REQ-027 A write with wr_bank>=NUM_BANKS or wr_addr>=DEPTH: the memory is not written, wr_cnt still increments, err_wr is set.
REQ-028 A wr_en=1 in READY or SERVE is dropped: the memory is not written and err_wr is set.
REQ-029 In SERVE, wr_en and fc_done in the same cycle: the write is dropped, err_wr is set, and the IDLE transition still occurs.
REQ-030 fc_done outside SERVE is ignored.
REQ-031 Read pipeline: rd_en/rd_bank/rd_addr are registered at cycle N, the array is read at N+1, and fc1_data is valid at N+2 (2-cycle latency, fully pipelined, one read per cycle).
REQ-032 fc1_data holds its last value when no read completes.
REQ-033 A read completing while the read was issued outside SERVE returns 0x00.
REQ-034 An out-of-range read returns 0x00.
REQ-035 The write and read ports are independent; a same-address read/write collision is impossible because writes and SERVE reads are mutually exclusive by state.
REQ-036 No arithmetic is performed on data; bytes are returned bit-exact.

Reset
REQ-037 rst=1 forces state IDLE, wr_cnt=0, both read pipeline stages cleared, valid=0, fc1_data=0x00, mode_q=0, busy=0 and err_wr=0, asynchronously.
REQ-038 Memory contents are not cleared by reset.
REQ-039 Reset asserted mid-FILL or mid-SERVE abandons the frame; the next frame restarts from IDLE.
REQ-040 err_wr is cleared only by rst.

Verification
REQ-041 Sequence: mode=0, FRAME_LEN0=8; write 8 bytes 0x10..0x17 to bank 3, addr 0..7 -> valid pulses exactly once, one cycle after the 8th write edge; busy=1 from the first write until fc_done.
REQ-042 Sequence: in SERVE, rd_en for bank 3 addr 0..7 on consecutive cycles -> fc1_data = 0x10..0x17 at cycles N+2..N+9.
REQ-043 Sequence: write with wr_bank=63, then with wr_bank=0 and wr_addr=2047 (NUM_BANKS=64), then read both in SERVE -> the stored bytes are returned; a read with addr >= DEPTH (DEPTH parameter reduced) returns 0x00 and err_wr is set by the corresponding write.
REQ-044 Sequence: wr_en together with fc_done in SERVE -> state goes to IDLE, err_wr=1, and the target memory location is unchanged.
REQ-045 Sequence: rst pulse after 5 of 8 writes, then 8 fresh writes with mode=1 and FRAME_LEN1=8 -> valid fires only after the 8 fresh writes; mode_q=1.
REQ-046 Sequence: rd_en in FILL -> fc1_data=0x00 two cycles later; rd_en idle -> fc1_data holds its value.
